// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the phase-shifted clock divider.
// Defaults here are the values used when the top is instantiated bare.
package clk_gen_pkg;

  localparam int N_CH_DEF    = 2;
  localparam int CNT_W_DEF   = 10;
  localparam int DIV_RST_DEF = 125;

  // Step counter width: enough to hold 0..2*N_CH-1.
  function automatic int step_w(input int n_ch);
    return (n_ch < 1) ? 1 : $clog2(2 * n_ch);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler with live-updatable divide value and a one-deep config slot.
// A new value waits in div_pend until the next tick edge.
module tick_prescaler
  import clk_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             rdy_q, rdy_d;

  assign tick      = en && (pre_q == div_q);
  assign cfg_ready = rdy_q;

  always_comb begin
    pre_d  = pre_q;
    div_d  = div_q;
    pend_d = pend_q;
    rdy_d  = rdy_q;
    if (en) begin
      pre_d = tick ? '0 : pre_q + ONE;
    end
    // rdy_q gates both branches, so apply and capture never coincide.
    if (tick && !rdy_q) begin
      div_d = pend_q;
      rdy_d = 1'b1;
    end
    if (cfg_valid && rdy_q) begin
      pend_d = cfg_div;
      rdy_d  = 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (!reset) begin
      pre_q  <= '0;
      div_q  <= DIV_INIT;
      pend_q <= DIV_INIT;
      rdy_q  <= 1'b1;
    end else begin
      pre_q  <= pre_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/phase_divider.sv
// N_CH divided clocks at 50% duty, channel i lagging channel 0 by i ticks,
// plus a frame pulse at the start of each output period.
module phase_divider
  import clk_gen_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic [N_CH-1:0]  clk_out,
  output logic             frame
);

  localparam int SW  = step_w(N_CH);
  localparam int PER = 2 * N_CH;

  localparam logic [SW-1:0] LAST   = SW'(PER - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW:0]   PER_W  = (SW+1)'(PER);
  localparam logic [SW:0]   HALF_W = (SW+1)'(N_CH);

  logic            tick;
  logic [SW-1:0]   step_q, step_d;
  logic [N_CH-1:0] clk_q, clk_d;
  logic            frame_q, frame_d;
  logic [SW:0]     rel;

  tick_prescaler #(
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) u_pre (
    .ck        (ck),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .tick      (tick)
  );

  always_comb begin
    step_d  = step_q;
    clk_d   = clk_q;
    frame_d = 1'b0;
    rel     = '0;
    if (tick) begin
      step_d = (step_q == LAST) ? '0 : step_q + S_ONE;
    end
    // Channel i is high while (step_next - i) mod 2N lies in [0, N).
    if (en) begin
      for (int i = 0; i < N_CH; i++) begin
        rel = {1'b0, step_d} + (SW+1)'(PER - i);
        if (rel >= PER_W) begin
          rel = rel - PER_W;
        end
        clk_d[i] = (rel < HALF_W);
      end
    end
    frame_d = tick && (step_q == LAST);
  end

  always_ff @(posedge ck) begin
    if (!reset) begin
      step_q  <= '0;
      clk_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      step_q  <= step_d;
      clk_q   <= clk_d;
      frame_q <= frame_d;
    end
  end

  assign clk_out = clk_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_phase_divider.sv
// Bench for phase_divider: two instances (2 and 4 channels) share stimulus
// and are compared each cycle against a tick-count reference model.
module tb_phase_divider;

  logic       ck = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [9:0] cfg_div = '0;
  logic       rdy2, rdy4, frame2, frame4;
  logic [1:0] clk2;
  logic [3:0] clk4;
  logic [9:0] obs;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int      m_pre = 0;
  int      m_div = 125;
  int      m_pend[$];
  longint  m_ticks = 0;
  logic [1:0] m_clk2 = '0;
  logic [3:0] m_clk4 = '0;
  logic    m_f2 = 1'b0;
  logic    m_f4 = 1'b0;

  always #5 ck = ~ck;

  phase_divider #(.N_CH(2), .CNT_W(10), .DIV_RST(125)) dut2 (
    .ck(ck), .reset(reset), .en(en), .cfg_valid(cfg_valid),
    .cfg_div(cfg_div), .cfg_ready(rdy2), .clk_out(clk2), .frame(frame2)
  );

  phase_divider #(.N_CH(4), .CNT_W(10), .DIV_RST(125)) dut4 (
    .ck(ck), .reset(reset), .en(en), .cfg_valid(cfg_valid),
    .cfg_div(cfg_div), .cfg_ready(rdy4), .clk_out(clk4), .frame(frame4)
  );

  assign obs = {rdy2, rdy4, frame2, frame4, clk2, clk4};

  function automatic logic [9:0] exp_v();
    logic rd;
    rd = (m_pend.size() == 0);
    return {rd, rd, m_f2, m_f4, m_clk2, m_clk4};
  endfunction

  // Output phase is a pure function of how many ticks have elapsed.
  function automatic logic ch_high(longint t, int i, int n);
    int r;
    r = int'((t - i) % (2 * n));
    if (r < 0) r += 2 * n;
    return r < n;
  endfunction

  task automatic model_update();
    bit tk, acc;
    if (!reset) begin
      m_pre = 0; m_div = 125; m_pend.delete(); m_ticks = 0;
      m_clk2 = '0; m_clk4 = '0; m_f2 = 1'b0; m_f4 = 1'b0;
      return;
    end
    tk  = en && (m_pre == m_div);
    acc = cfg_valid && (m_pend.size() == 0);
    m_f2 = tk && (m_ticks % 4 == 3);
    m_f4 = tk && (m_ticks % 8 == 7);
    if (en) begin
      if (tk) begin
        m_pre = 0;
        m_ticks++;
        if (m_pend.size() > 0) m_div = m_pend.pop_front();
      end else begin
        m_pre++;
      end
      for (int i = 0; i < 2; i++) m_clk2[i] = ch_high(m_ticks, i, 2);
      for (int i = 0; i < 4; i++) m_clk4[i] = ch_high(m_ticks, i, 4);
    end
    if (acc) m_pend.push_back(int'(cfg_div));
  endtask

  task automatic drive(input bit r, input bit e, input bit v, input int d);
    @(negedge ck);
    reset = r; en = e; cfg_valid = v; cfg_div = 10'(d);
    @(posedge ck);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 5);
    drive(0, 1, 1, 5);
    if (obs !== 10'b11_0_0_00_0000) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 10'b1100000000);
    end
    checks++;
  endtask

  task automatic test_period_n2();
    int r0[$], r1[$], f0[$], fr[$];
    logic [1:0] p2;
    drive(0, 1, 0, 0);
    p2 = clk2;
    for (int k = 0; k < 1200; k++) begin
      drive(1, 1, 0, 0);
      if (k == 0) begin
        if (clk2 !== 2'b01 || clk4 !== 4'b0001) begin
          errors++;
          $display("FAIL first_edge got=%b/%b want=01/0001", clk2, clk4);
        end
        checks++;
      end
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL period_n2 k=%0d got=%b want=%b", k, obs, exp_v());
      end
      checks++;
      if (clk2[0] && !p2[0]) r0.push_back(k);
      if (!clk2[0] && p2[0]) f0.push_back(k);
      if (clk2[1] && !p2[1]) r1.push_back(k);
      if (frame2) fr.push_back(k);
      p2 = clk2;
    end
    if (r0.size() != 3 || r1.size() != 3 || f0.size() < 2 || fr.size() != 2) begin
      errors++;
      $display("FAIL period_counts got r0=%0d r1=%0d f0=%0d fr=%0d want 3 3 2 2",
               r0.size(), r1.size(), f0.size(), fr.size());
      checks++;
    end else begin
      if (r0[2] - r0[1] != 504) begin
        errors++;
        $display("FAIL period_504 got=%0d want=504", r0[2] - r0[1]);
      end
      checks++;
      if (r1[1] - r0[1] != 126) begin
        errors++;
        $display("FAIL lag_126 got=%0d want=126", r1[1] - r0[1]);
      end
      checks++;
      if (f0[1] - r0[1] != 252) begin
        errors++;
        $display("FAIL duty_252 got=%0d want=252", f0[1] - r0[1]);
      end
      checks++;
      if (fr[0] != r0[1] || fr[1] != r0[2]) begin
        errors++;
        $display("FAIL frame_pos got=%0d,%0d want=%0d,%0d", fr[0], fr[1], r0[1], r0[2]);
      end
      checks++;
    end
  endtask

  task automatic test_fast_n4();
    int r4[4][$];
    logic [3:0] p4;
    drive(0, 1, 0, 0);
    p4 = clk4;
    for (int k = 0; k < 200; k++) begin
      drive(1, 1, k == 0, 0);
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL fast_n4 k=%0d got=%b want=%b", k, obs, exp_v());
      end
      checks++;
      if (k >= 130) begin
        if (clk4[0] && !p4[0]) r4[0].push_back(k);
        for (int i = 1; i < 4; i++)
          if (clk4[i] && !p4[i] && r4[0].size() > 0) r4[i].push_back(k);
      end
      p4 = clk4;
    end
    for (int i = 0; i < 4; i++) begin
      if (r4[i].size() < 2 || r4[0].size() < 1) begin
        errors++;
        $display("FAIL fast_rises ch=%0d got=%0d want>=2", i, r4[i].size());
      end else if (r4[i][1] - r4[i][0] != 8 || r4[i][0] - r4[0][0] != i) begin
        errors++;
        $display("FAIL fast_phase ch=%0d got per=%0d lag=%0d want 8 %0d",
                 i, r4[i][1] - r4[i][0], r4[i][0] - r4[0][0], i);
      end
      checks++;
    end
  endtask

  task automatic test_mid_change();
    int a, n;
    int ch[$];
    logic [3:0] p4;
    drive(0, 1, 0, 0);
    drive(1, 1, 1, 9);
    if (rdy2 !== 1'b0 || obs !== exp_v()) begin
      errors++;
      $display("FAIL mid_accept9 got=%b want=%b", obs, exp_v());
    end
    checks++;
    n = 0;
    while (rdy2 !== 1'b1 && n < 300) begin
      drive(1, 1, 0, 0);
      n++;
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL mid_wait n=%0d got=%b want=%b", n, obs, exp_v());
      end
      checks++;
    end
    a = cyc;
    for (int k = 0; k < 4; k++) drive(1, 1, 0, 0);
    drive(1, 1, 1, 3);
    if (rdy2 !== 1'b0) begin
      errors++;
      $display("FAIL mid_accept3 got=%b want=0", rdy2);
    end
    checks++;
    p4 = clk4;
    for (int k = 0; k < 30; k++) begin
      drive(1, 1, 0, 0);
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL mid_run k=%0d got=%b want=%b", k, obs, exp_v());
      end
      checks++;
      if (clk4 !== p4) ch.push_back(cyc);
      p4 = clk4;
    end
    if (ch.size() < 3) begin
      errors++;
      $display("FAIL mid_ticks got=%0d want>=3", ch.size());
    end else if (ch[0] - a != 10 || ch[1] - ch[0] != 4 || ch[2] - ch[1] != 4) begin
      errors++;
      $display("FAIL mid_spacing got=%0d,%0d,%0d want=10,4,4",
               ch[0] - a, ch[1] - ch[0], ch[2] - ch[1]);
    end
    checks++;
  endtask

  task automatic test_en_freeze();
    logic [1:0] s2;
    logic [3:0] s4;
    int ee, fe;
    drive(0, 1, 0, 0);
    ee = 0;
    fe = -1;
    for (int k = 0; k < 300; k++) begin
      drive(1, 1, 0, 0);
      ee++;
    end
    s2 = clk2;
    s4 = clk4;
    for (int k = 0; k < 37; k++) begin
      drive(1, 0, 0, 0);
      if (clk2 !== s2 || clk4 !== s4 || frame2 !== 1'b0 || frame4 !== 1'b0) begin
        errors++;
        $display("FAIL en_frozen k=%0d got=%b/%b/%b want=%b/%b/0",
                 k, clk2, clk4, frame2, s2, s4);
      end
      checks++;
    end
    for (int k = 0; k < 600; k++) begin
      drive(1, 1, 0, 0);
      if (frame2 && fe < 0) fe = ee;
      ee++;
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL en_resume k=%0d got=%b want=%b", k, obs, exp_v());
      end
      checks++;
    end
    if (fe != 503) begin
      errors++;
      $display("FAIL en_frame_edge got=%0d want=503", fe);
    end
    checks++;
  endtask

  task automatic test_reset_pending();
    int ch[$];
    logic [3:0] p4;
    drive(0, 1, 0, 0);
    for (int k = 0; k < 50; k++) drive(1, 1, 0, 0);
    drive(1, 1, 1, 7);
    for (int k = 0; k < 20; k++) drive(1, 1, 0, 0);
    drive(0, 1, 1, 3);
    if (obs !== 10'b11_0_0_00_0000) begin
      errors++;
      $display("FAIL rst_pending got=%b want=1100000000", obs);
    end
    checks++;
    p4 = clk4;
    for (int k = 0; k < 300; k++) begin
      drive(1, 1, 0, 0);
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL rst_run k=%0d got=%b want=%b", k, obs, exp_v());
      end
      checks++;
      if (clk4 !== p4) ch.push_back(k);
      p4 = clk4;
    end
    if (ch.size() < 3 || ch[0] != 0 || ch[1] != 125 || ch[2] != 251) begin
      errors++;
      $display("FAIL rst_div got=%0d changes want edges 0,125,251", ch.size());
    end
    checks++;
  endtask

  task automatic test_valid_hold();
    int a, n;
    int ch[$];
    logic [3:0] p4;
    drive(0, 1, 0, 0);
    drive(1, 1, 1, 2);
    n = 0;
    while (rdy2 !== 1'b1 && n < 300) begin
      drive(1, 1, 1, 20);
      n++;
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL hold_wait n=%0d got=%b want=%b", n, obs, exp_v());
      end
      checks++;
    end
    a = cyc;
    p4 = clk4;
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 0);
      if (clk4 !== p4) ch.push_back(cyc);
      p4 = clk4;
    end
    if (ch.size() < 2 || ch[0] - a != 3 || ch[1] - ch[0] != 3) begin
      errors++;
      $display("FAIL hold_div got=%0d changes want spacing 3,3", ch.size());
    end
    checks++;
  endtask

  task automatic test_random();
    bit r, e, v;
    int d;
    drive(0, 1, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 7) == 0);
      d = $urandom_range(0, 12);
      drive(r, e, v, d);
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL random k=%0d got=%b want=%b", k, obs, exp_v());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_period_n2();
    test_fast_n4();
    test_mid_change();
    test_en_freeze();
    test_reset_pending();
    test_valid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
